axis_reg_pipe: RTL

Parametrised AXI4-Stream register pipeline: a chain of `DEPTH` full-throughput skid-buffered register stages carrying tdata/tlast (optionally tkeep) between a slave and a master stream port. It is the successor of the single-stage stream register slice and is used to break long timing paths on stream datapaths without losing one-beat-per-cycle throughput. It also reports buffered-beat occupancy and a completed-packet count.

---
 rtl/axis_reg_pkg.sv | 11 +
 rtl/axis_skid_stage.sv | 54 +++++
 rtl/axis_reg_pipe.sv | 70 +++++++
 3 files changed

// File: rtl/axis_reg_pkg.sv
// axis_reg_pkg: stage-state encoding and width helpers shared by the axis_reg_pipe slice
package axis_reg_pkg;
  // Encodings double as the number of beats a stage holds (0, 1 or 2).
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_BUSY = 2'd1, ST_FULL = 2'd2} stage_st_t;
  function automatic int keep_width(input int data_width);
    return data_width / 8;
  endfunction
  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction
endpackage

// File: rtl/axis_skid_stage.sv
// axis_skid_stage: one full-throughput skid-buffered register stage with held-beat count
module axis_skid_stage
  import axis_reg_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [1:0]   count
);
  stage_st_t st, st_nxt;
  logic [W-1:0] skid;
  logic rdy, in_x, out_x;
  assign in_x = s_valid & rdy;
  assign out_x = m_valid & m_ready;
  assign s_ready = rdy;
  assign m_valid = st != ST_EMPTY;
  assign count = st;
  // Next state from the in/out transfer pair seen this cycle
  always_comb begin
    st_nxt = st;
    case (st)
      ST_EMPTY: st_nxt = in_x ? ST_BUSY : ST_EMPTY;
      ST_BUSY:  st_nxt = (in_x & ~out_x) ? ST_FULL : (~in_x & out_x) ? ST_EMPTY : ST_BUSY;
      ST_FULL:  st_nxt = out_x ? ST_BUSY : ST_FULL;
      default:  st_nxt = ST_EMPTY;
    endcase
  end
  // State and ready register; ready is computed from the next state so it never sees m_ready combinationally
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= ST_EMPTY;
      rdy <= 1'b0;
    end else begin
      st <= st_nxt;
      rdy <= st_nxt != ST_FULL;
    end
  // Main register feeds the output; skid catches the beat that arrives while the output is stalled
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      m_data <= '0;
      skid <= '0;
    end else begin
      if (st == ST_FULL && out_x) m_data <= skid;
      else if (in_x && (st == ST_EMPTY || out_x)) m_data <= s_data;
      if (st == ST_BUSY && in_x && !out_x) skid <= s_data;
    end
endmodule

// File: rtl/axis_reg_pipe.sv
// axis_reg_pipe: DEPTH-stage skid-buffered AXI4-Stream register pipeline; tkeep carried when AXIS_REG_PIPE_TKEEP_EN is defined
module axis_reg_pipe
  import axis_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
`ifdef AXIS_REG_PIPE_TKEEP_EN
  input  logic [keep_width(DATA_WIDTH)-1:0] s_axis_tkeep,
`endif
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
`ifdef AXIS_REG_PIPE_TKEEP_EN
  output logic [keep_width(DATA_WIDTH)-1:0] m_axis_tkeep,
`endif
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [occ_width(DEPTH)-1:0]   occupancy,
  output logic [CNT_WIDTH-1:0]          pkt_count
);
`ifdef AXIS_REG_PIPE_TKEEP_EN
  localparam int PW = DATA_WIDTH + keep_width(DATA_WIDTH) + 1;
`else
  localparam int PW = DATA_WIDTH + 1;
`endif
  localparam int OW = occ_width(DEPTH);
  logic [DEPTH:0][PW-1:0] pl;
  logic [DEPTH:0] vld, rdy;
  logic [DEPTH-1:0][1:0] cnt;
`ifdef AXIS_REG_PIPE_TKEEP_EN
  assign pl[0] = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = pl[DEPTH];
`else
  assign pl[0] = {s_axis_tdata, s_axis_tlast};
  assign {m_axis_tdata, m_axis_tlast} = pl[DEPTH];
`endif
  assign vld[0] = s_axis_tvalid;
  assign s_axis_tready = rdy[0];
  assign m_axis_tvalid = vld[DEPTH];
  assign rdy[DEPTH] = m_axis_tready;
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    axis_skid_stage #(.W(PW)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .s_data  (pl[g]),
      .s_valid (vld[g]),
      .s_ready (rdy[g]),
      .m_data  (pl[g+1]),
      .m_valid (vld[g+1]),
      .m_ready (rdy[g+1]),
      .count   (cnt[g])
    );
  end
  // Total beats held across all stages
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) occupancy = occupancy + OW'(cnt[k]);
  end
  // Count packets completed on the master port, wrapping naturally
  always_ff @(posedge clk or negedge reset)
    if (!reset) pkt_count <= '0;
    else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) pkt_count <= pkt_count + 1'b1;
endmodule
